sgdma_descriptor_reader: RTL and testbench

Avalon-MM master that walks a linked chain of DMA descriptors held in the dual-port descriptor memory, hands each hardware-owned descriptor to the DMA datapath over a valid/ready handshake, and writes completion status back into the same descriptor. It is the consumer of the descriptor memory's second port: software builds descriptors through one port, and this block reads and retires them through the other.

---
 rtl/sgdma_descriptor_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_sgdma_descriptor_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdma_descriptor_reader.sv
// Descriptor chain walker: fetches 16-byte descriptors over an Avalon-MM
// master, offers hardware-owned ones to the DMA datapath, and writes the
// completion status back into word 3 of each retired descriptor.
module sgdma_descriptor_reader #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] head_ptr,
  output logic              busy,
  output logic              chain_done,
  output logic              error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [ADDR_W-1:0] desc_src,
  output logic [ADDR_W-1:0] desc_dst,
  output logic [15:0]       desc_len,
  output logic [7:0]        desc_ctrl,
  input  logic              cmpl_valid,
  input  logic [7:0]        cmpl_status,
  input  logic [15:0]       cmpl_len
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned STS_W  = 8;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_PRESENT, S_EXEC, S_WB, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   next_q, next_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [STS_W-1:0]    cst_q, cst_d;
  logic [LEN_W-1:0]    clen_q, clen_d;
  logic                stop_pend_q, stop_pend_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                m_read_q, m_read_d;
  logic                m_write_q, m_write_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic                desc_valid_q, desc_valid_d;
  logic                stop_seen;
  logic [IDX_W-1:0]    addr_idx;

  // State and datapath registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      next_q       <= '0;
      len_q        <= '0;
      ctrl_q       <= '0;
      cst_q        <= '0;
      clen_q       <= '0;
      stop_pend_q  <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      desc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      next_q       <= next_d;
      len_q        <= len_d;
      ctrl_q       <= ctrl_d;
      cst_q        <= cst_d;
      clen_q       <= clen_d;
      stop_pend_q  <= stop_pend_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      desc_valid_q <= desc_valid_d;
    end
  end

  // Next-state logic; bus/handshake outputs are decoded from the next state
  // so they are registered yet line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    src_d       = src_q;
    dst_d       = dst_q;
    next_d      = next_q;
    len_d       = len_q;
    ctrl_d      = ctrl_q;
    cst_d       = cst_q;
    clen_d      = clen_q;
    error_d     = error_q;
    done_d      = 1'b0;
    stop_seen   = stop_pend_q | stop;
    stop_pend_d = stop_pend_q | ((state_q != S_IDLE) & stop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = head_ptr;
          idx_d   = '0;
          error_d = 1'b0;
          if (head_ptr[3:0] != 4'h0) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (!m_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (m_readdatavalid) begin
          case (idx_q)
            2'd0: src_d  = ADDR_W'(m_readdata);
            2'd1: dst_d  = ADDR_W'(m_readdata);
            2'd2: next_d = ADDR_W'(m_readdata);
            default: begin
              len_d  = m_readdata[15:0];
              ctrl_d = m_readdata[31:24];
            end
          endcase
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? S_CHECK : S_RD_REQ;
        end
      end
      S_CHECK: begin
        if (!ctrl_q[7]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (stop_seen) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (desc_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cmpl_valid) begin
          cst_d   = cmpl_status;
          clen_d  = cmpl_len;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (!m_waitrequest) begin
          if (ctrl_q[0]) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (next_q[3:0] != 4'h0) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else if (stop_seen) begin
            state_d = S_IDLE;
          end else begin
            base_d  = next_q;
            idx_d   = '0;
            state_d = S_RD_REQ;
          end
        end
      end
      S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_pend_d = 1'b0;

    addr_idx     = (state_d == S_WB) ? 2'd3 : idx_d;
    busy_d       = (state_d != S_IDLE);
    m_read_d     = (state_d == S_RD_REQ);
    m_write_d    = (state_d == S_WB);
    desc_valid_d = (state_d == S_PRESENT);
    m_addr_d     = base_d + ADDR_W'({addr_idx, 2'b00});
    m_wdata_d    = {ctrl_q & 8'h7F, cst_d, clen_d};
  end

  assign busy         = busy_q;
  assign chain_done   = done_q;
  assign error        = error_q;
  assign m_address    = m_addr_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_wdata_q;
  assign m_byteenable = 4'hF;
  assign desc_valid   = desc_valid_q;
  assign desc_src     = src_q;
  assign desc_dst     = dst_q;
  assign desc_len     = len_q;
  assign desc_ctrl    = ctrl_q;

endmodule

// File: tb/tb_sgdma_descriptor_reader.sv
// Scoreboard bench for sgdma_descriptor_reader: a memory slave, a datapath
// responder, and monitors that pop expected bus ops/descriptors on the fly.
module tb_sgdma_descriptor_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [31:0] head_ptr;
  logic        busy, chain_done, error;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_src, desc_dst;
  logic [15:0] desc_len;
  logic [7:0]  desc_ctrl;
  logic        cmpl_valid;
  logic [7:0]  cmpl_status;
  logic [15:0] cmpl_len;

  always #5 clk = ~clk;

  sgdma_descriptor_reader #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .head_ptr(head_ptr),
    .busy(busy), .chain_done(chain_done), .error(error),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_ctrl(desc_ctrl),
    .cmpl_valid(cmpl_valid), .cmpl_status(cmpl_status), .cmpl_len(cmpl_len)
  );

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [31:0] src; logic [31:0] dst; logic [15:0] len; logic [7:0] ctrl; } desc_t;
  typedef struct { logic [7:0] st; logic [15:0] len; } cmpl_t;

  bus_t  exp_bus[$];
  desc_t exp_desc[$];
  cmpl_t cmpl_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int start_cyc, valid_cyc, done_cyc, wr_cyc, cmpl_cyc;
  int done_cnt = 0;
  int dp_cnt = 0;
  int stop_on = -1;
  int wait_states = 0;
  int wait_cnt;
  logic [31:0] mem [0:127];
  logic prev_valid;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Memory slave with programmable wait states and read latency 1
  assign m_waitrequest = (m_read || m_write) && (wait_cnt < wait_states);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt        <= 0;
      m_readdatavalid <= 1'b0;
      m_readdata      <= '0;
    end else begin
      m_readdatavalid <= 1'b0;
      if (m_read || m_write) begin
        if (m_waitrequest) wait_cnt <= wait_cnt + 1;
        else begin
          wait_cnt <= 0;
          if (m_read) begin
            m_readdatavalid <= 1'b1;
            m_readdata      <= mem[m_address[8:2]];
          end
        end
      end
    end
  end

  // Bus monitor: every stalled or accepted access is checked against the queue head
  initial begin : bus_mon
    bus_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (m_read || m_write)) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", {30'b0, m_read, m_write}, 32'h0);
        end else if (m_waitrequest) begin
          chk("stall_addr", m_address, exp_bus[0].addr);
          chk("stall_dir", 32'(m_write), 32'(exp_bus[0].wr));
          if (exp_bus[0].wr) chk("stall_wdata", m_writedata, exp_bus[0].data);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_dir", 32'(m_write), 32'(e.wr));
          chk("bus_addr", m_address, e.addr);
          if (e.wr) begin
            chk("wb_data", m_writedata, e.data);
            chk("byteenable", 32'(m_byteenable), 32'hF);
            wr_cyc = cyc;
          end
        end
      end
    end
  end

  // Descriptor monitor: handshakes are compared in order
  initial begin : desc_mon
    desc_t d;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (desc_valid && !prev_valid) valid_cyc = cyc;
      prev_valid = desc_valid;
      if (desc_valid && desc_ready) begin
        if (exp_desc.size() == 0) chk("desc_unexpected", 32'(desc_valid), 32'h0);
        else begin
          d = exp_desc.pop_front();
          chk("desc_src", desc_src, d.src);
          chk("desc_dst", desc_dst, d.dst);
          chk("desc_len", 32'(desc_len), 32'(d.len));
          chk("desc_ctrl", 32'(desc_ctrl), 32'(d.ctrl));
        end
      end
    end
  end

  // chain_done monitor
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (chain_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'h0);
      end
    end
  end

  // Datapath responder: accept a cycle after valid, complete a few cycles later
  initial begin : datapath
    cmpl_t c;
    desc_ready = 1'b0; cmpl_valid = 1'b0; cmpl_status = '0; cmpl_len = '0; stop = 1'b0;
    forever begin
      @(negedge clk);
      if (desc_valid && !desc_ready) begin
        @(posedge clk); #1 desc_ready = 1'b1;
        @(posedge clk); #1 desc_ready = 1'b0;
        dp_cnt++;
        if (dp_cnt == stop_on) begin
          stop = 1'b1;
          @(posedge clk); #1 stop = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        c = (cmpl_q.size() != 0) ? cmpl_q.pop_front() : '{8'h0, 16'h0};
        cmpl_status = c.st; cmpl_len = c.len; cmpl_valid = 1'b1; cmpl_cyc = cyc;
        @(posedge clk); #1 cmpl_valid = 1'b0;
      end
    end
  end

  task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] n, input logic [31:0] w3);
    mem[a[8:2]] = s; mem[a[8:2]+1] = d; mem[a[8:2]+2] = n; mem[a[8:2]+3] = w3;
  endtask

  task automatic exp_reads(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_bus.push_back('{1'b0, a + 32'(4*i), 32'h0});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back('{1'b1, a, d});
  endtask

  task automatic start_chain(input logic [31:0] hp);
    @(posedge clk); #1 start = 1'b1; head_ptr = hp;
    @(posedge clk); #1 start = 1'b0; start_cyc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    chk({name, "_busy_fell"}, 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic end_test(input string name, input int exp_done, input logic exp_err);
    chk({name, "_bus_left"}, 32'(exp_bus.size()), 32'h0);
    chk({name, "_desc_left"}, 32'(exp_desc.size()), 32'h0);
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    chk({name, "_error"}, 32'(error), 32'(exp_err));
    done_cnt = 0;
  endtask

  initial begin : main
    int n;
    reset_n = 1'b0; start = 1'b0; head_ptr = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_outs", {26'b0, m_read, m_write, desc_valid, error, chain_done, 1'b0}, 32'h0);
    chk("rst_addr", m_address, 32'h0);
    chk("rst_be", 32'(m_byteenable), 32'hF);

    // T1: single descriptor at 0x100
    put_desc(32'h100, 32'hA000_0000, 32'hB000_0000, 32'h0, 32'h8100_0040);
    exp_reads(32'h100);
    exp_desc.push_back('{32'hA000_0000, 32'hB000_0000, 16'd64, 8'h81});
    cmpl_q.push_back('{8'h00, 16'd64});
    exp_write(32'h10C, 32'h0100_0040);
    start_chain(32'h100);
    wait_idle("t1");
    chk("t1_valid_latency", 32'(valid_cyc - start_cyc), 32'd9);
    chk("t1_wb_latency", 32'(wr_cyc - cmpl_cyc), 32'd1);
    end_test("t1", 1, 1'b0);

    // T2: two-descriptor chain 0x000 -> 0x010
    put_desc(32'h000, 32'h1000, 32'h2000, 32'h010, 32'h8000_0020);
    put_desc(32'h010, 32'h3000, 32'h4000, 32'h0, 32'h8100_0008);
    exp_reads(32'h000);
    exp_desc.push_back('{32'h1000, 32'h2000, 16'd32, 8'h80});
    cmpl_q.push_back('{8'h00, 16'd32});
    exp_write(32'h00C, 32'h0000_0020);
    exp_reads(32'h010);
    exp_desc.push_back('{32'h3000, 32'h4000, 16'd8, 8'h81});
    cmpl_q.push_back('{8'h05, 16'd7});
    exp_write(32'h01C, 32'h0105_0007);
    start_chain(32'h000);
    wait_idle("t2");
    end_test("t2", 1, 1'b0);

    // T3: head not owned by hardware
    put_desc(32'h040, 32'h5, 32'h6, 32'h0, 32'h0000_0010);
    exp_reads(32'h040);
    start_chain(32'h040);
    wait_idle("t3");
    chk("t3_done_latency", 32'(done_cyc - start_cyc), 32'd9);
    end_test("t3", 1, 1'b0);

    // T4: three wait states on every access
    wait_states = 3;
    put_desc(32'h080, 32'h1111_2222, 32'h3333_4444, 32'h0, 32'h81AA_0100);
    exp_reads(32'h080);
    exp_desc.push_back('{32'h1111_2222, 32'h3333_4444, 16'h0100, 8'h81});
    cmpl_q.push_back('{8'h7E, 16'h00FF});
    exp_write(32'h08C, 32'h017E_00FF);
    start_chain(32'h080);
    wait_idle("t4");
    end_test("t4", 1, 1'b0);
    wait_states = 0;

    // T5: stop during EXEC of the first of three descriptors
    put_desc(32'h0C0, 32'h10, 32'h20, 32'h0D0, 32'h8000_0010);
    put_desc(32'h0D0, 32'h30, 32'h40, 32'h0E0, 32'h8000_0010);
    put_desc(32'h0E0, 32'h50, 32'h60, 32'h0, 32'h8100_0010);
    exp_reads(32'h0C0);
    exp_desc.push_back('{32'h10, 32'h20, 16'h10, 8'h80});
    cmpl_q.push_back('{8'h00, 16'h10});
    exp_write(32'h0CC, 32'h0000_0010);
    dp_cnt = 0; stop_on = 1;
    start_chain(32'h0C0);
    wait_idle("t5");
    end_test("t5", 0, 1'b0);
    stop_on = -1;

    // T6: misaligned head, then a clean start clears error
    start_chain(32'h104);
    wait_idle("t6a");
    end_test("t6a", 0, 1'b1);
    exp_reads(32'h100);
    exp_desc.push_back('{32'hA000_0000, 32'hB000_0000, 16'd64, 8'h81});
    cmpl_q.push_back('{8'h00, 16'd64});
    exp_write(32'h10C, 32'h0100_0040);
    start_chain(32'h100);
    chk("t6_error_clear", 32'(error), 32'h0);
    wait_idle("t6b");
    end_test("t6b", 1, 1'b0);

    // T7: reset during RD_WAIT
    exp_bus.push_back('{1'b0, 32'h100, 32'h0});
    start_chain(32'h100);
    n = 0;
    while (!(m_read && !m_waitrequest) && n < 50) begin @(negedge clk); n++; end
    chk("t7_read_seen", 32'(m_read), 32'h1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(busy), 32'h0);
    chk("t7_rst_outs", {26'b0, m_read, m_write, desc_valid, error, chain_done, 1'b0}, 32'h0);
    chk("t7_rst_addr", m_address, 32'h0);
    chk("t7_rst_src", desc_src, 32'h0);
    chk("t7_rst_be", 32'(m_byteenable), 32'hF);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t7_idle_busy", 32'(busy), 32'h0);
    end_test("t7", 0, 1'b0);
    chk("cmpl_left", 32'(cmpl_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
